regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
Sequential debug reader for the CPU register file. On a start command it walks a range of register addresses through one read port, samples each value and streams it out with a valid/ready handshake. It sits between the register file's spare read port and the display/UART debug path. It is the read-side counterpart of the writeback path that fills the register file.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register address width; the file holds 2**ADDR_WIDTH entries

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Start  input  1  one-cycle command; sampled only in IDLE
Abort  input  1  synchronous cancel of a dump in progress
SkipZero  input  1  when 1, zero-valued registers are not emitted; latched on Start
StartAddr  input  ADDR_WIDTH  first address; latched on Start
EndAddr  input  ADDR_WIDTH  last address, inclusive; latched on Start
RAddr  output  ADDR_WIDTH  address driven to the register file read port
RData  input  DATA_WIDTH  combinational read data returned for RAddr
Dout  output  DATA_WIDTH  sampled register value
DoutAddr  output  ADDR_WIDTH  address that Dout belongs to
Valid  output  1  Dout/DoutAddr valid
Ready  input  1  consumer accepts when Valid && Ready
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle pulse when a dump completes normally

Behaviour:
- Reset (Rst_n=0, asynchronous): state IDLE; RAddr, Dout, DoutAddr, cur, end, skip = 0; Valid, Busy, Done = 0.
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - On Start=1: latch cur=StartAddr, end=EndAddr, skip=SkipZero; go to READ.
  - Otherwise remain in IDLE.
- READ:
  - RAddr=cur (registered; equals cur during the whole state).
  - If skip && RData==0 (non-emitting case):
    - cur==end: go to DONE.
    - Otherwise: cur=cur+1 (mod 2**ADDR_WIDTH) and stay in READ.
  - Otherwise (emitting case): at the clock edge, Dout<=RData, DoutAddr<=cur, Valid<=1; go to SEND.
- SEND:
  - Dout, DoutAddr and Valid are held stable until the cycle where Valid && Ready.
  - On that edge Valid<=0, then:
    - cur==end: go to DONE.
    - Otherwise: cur=cur+1 and go to READ.
  - Valid never drops without a handshake, except on Abort or reset.
- DONE: Done=1 for exactly one cycle, Busy=1; go to IDLE.
- Latency and throughput:
  - Start to first Valid: 2 edges (Start sampled, then READ).
  - Best-case throughput: 1 word per 2 cycles with Ready held high.
- Range and wrap-around:
  - Words visited = ((end - start) mod 2**ADDR_WIDTH) + 1.
  - end < start wraps from the top address through 0.
  - start == end visits exactly one register.
- Register 0 always reads 0. With SkipZero=1 it is never emitted.
- Data snapshot: each value is the RData sampled in its READ cycle. Writes to that register after sampling are not reflected.
- Start while Busy is ignored, including in DONE.
- Abort while Busy: next state IDLE; Valid=0, Busy=0; no Done pulse. Abort takes priority over Ready and over the DONE transition. Abort in IDLE has no effect; if Start and Abort are both high in IDLE, Start wins.
- Rst_n asserted mid-dump: immediate return to the reset values; no Done pulse.
- Done and Valid are never high in the same cycle.

Decomposition:
- Shared package:
  - State encoding (IDLE=2'd0, READ=2'd1, SEND=2'd2, DONE=2'd3).
  - DATA_WIDTH and ADDR_WIDTH defaults, shared with the register file.
- No sub-module: the address counter and FSM live in a single module.
- The register file instance connects RAddr to Addr2 (or a dedicated debug port) and R2 to RData.

Test Plan:
- Full dump: StartAddr=0, EndAddr=31, SkipZero=0, Ready=1, regs[i]=i*3. Expect 32 handshakes with DoutAddr 0..31 and Dout 0,3,...,93; Done pulse one cycle after the last handshake; total 65 cycles Start-to-Done.
- Backpressure: range 8..10, Ready low for 5 cycles at each Valid. Expect Dout/DoutAddr stable while Valid && !Ready; exactly 3 words; no duplicates or drops.
- Wrap and single word:
  - 30..1 yields addresses 30, 31, 0, 1.
  - 7..7 yields one word (addr 7), then Done.
- SkipZero: regs 0..5 = {0, 5, 0, 0, 9, 0}, range 0..5, SkipZero=1. Expect exactly (1,5) and (4,9); Done follows the READ of addr 5.
- Abort and reset:
  - Abort asserted in SEND with Ready=0: Valid and Busy low next cycle, no Done.
  - A new Start then runs a clean dump.
  - Rst_n pulsed mid-READ: all outputs 0 immediately (asynchronously).
- Coherency and Start-ignore:
  - A write to regs[12] in the cycle after its READ sample is not reflected in Dout.
  - Start pulsed while Busy does not restart the range.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file debug dump reader.
// Also holds the default widths that the register file itself uses.
package regfile_dump_reader_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive, wrapping address range on a spare register-file read port.
// Each sampled word is streamed out over a valid/ready handshake.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic                  SkipZero,
  input  logic [ADDR_WIDTH-1:0] StartAddr,
  input  logic [ADDR_WIDTH-1:0] EndAddr,
  output logic [ADDR_WIDTH-1:0] RAddr,
  input  logic [DATA_WIDTH-1:0] RData,
  output logic [DATA_WIDTH-1:0] Dout,
  output logic [ADDR_WIDTH-1:0] DoutAddr,
  output logic                  Valid,
  input  logic                  Ready,
  output logic                  Busy,
  output logic                  Done
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cur_q;
  logic [ADDR_WIDTH-1:0] end_q;
  logic                  skip_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [ADDR_WIDTH-1:0] dout_addr_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;

  logic last_addr;
  logic zero_skip;

  assign last_addr = (cur_q == end_q);
  assign zero_skip = skip_q && (RData == '0);

  // NOTE: all state lives in one clocked block with non-blocking assignments,
  // so every right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      end_q       <= '0;
      skip_q      <= 1'b0;
      dout_q      <= '0;
      dout_addr_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Abort beats Ready and the DONE exit; it never produces a Done pulse.
      if (Abort && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (Start) begin
              cur_q   <= StartAddr;
              end_q   <= EndAddr;
              skip_q  <= SkipZero;
              busy_q  <= 1'b1;
              state_q <= S_READ;
            end
          end
          S_READ: begin
            if (zero_skip) begin
              if (last_addr) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                cur_q <= cur_q + 1'b1;
              end
            end else begin
              dout_q      <= RData;
              dout_addr_q <= cur_q;
              valid_q     <= 1'b1;
              state_q     <= S_SEND;
            end
          end
          S_SEND: begin
            if (Ready) begin
              valid_q <= 1'b0;
              if (last_addr) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                cur_q   <= cur_q + 1'b1;
                state_q <= S_READ;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // The read port address tracks the walk counter directly, so it is stable for all of READ.
  assign RAddr    = cur_q;
  assign Dout     = dout_q;
  assign DoutAddr = dout_addr_q;
  assign Valid    = valid_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: directed scenarios plus randomized dumps
// checked against a queue of expected words computed from the range rules.
module tb_regfile_dump_reader;
  import regfile_dump_reader_pkg::*;

  localparam int DW = DATA_WIDTH_DEF;
  localparam int AW = ADDR_WIDTH_DEF;
  localparam int N  = 1 << AW;

  logic          Clk       = 1'b0;
  logic          Rst_n     = 1'b1;
  logic          Start     = 1'b0;
  logic          Abort     = 1'b0;
  logic          SkipZero  = 1'b0;
  logic          Ready     = 1'b0;
  logic [AW-1:0] StartAddr = '0;
  logic [AW-1:0] EndAddr   = '0;
  logic [AW-1:0] RAddr;
  logic [AW-1:0] DoutAddr;
  logic [DW-1:0] RData;
  logic [DW-1:0] Dout;
  logic          Valid;
  logic          Busy;
  logic          Done;

  logic [DW-1:0] regs [N];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } word_t;

  word_t exp_q[$];

  regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Start    (Start),
    .Abort    (Abort),
    .SkipZero (SkipZero),
    .StartAddr(StartAddr),
    .EndAddr  (EndAddr),
    .RAddr    (RAddr),
    .RData    (RData),
    .Dout     (Dout),
    .DoutAddr (DoutAddr),
    .Valid    (Valid),
    .Ready    (Ready),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clk = ~Clk;

  // Register file model: register 0 is hardwired to zero.
  always_comb begin
    RData = regs[RAddr];
    if (RAddr == '0) RData = '0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expected stream from the range rules applied to a snapshot of the file at Start.
  function automatic void build_expected(input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                                         input logic sk);
    int    cnt;
    int    a;
    word_t w;
    exp_q.delete();
    cnt = ((int'(ea) - int'(sa) + N) % N) + 1;
    for (int k = 0; k < cnt; k++) begin
      a      = (int'(sa) + k) % N;
      w.addr = AW'(a);
      w.data = (a == 0) ? '0 : regs[a];
      if (!(sk && (w.data == '0))) exp_q.push_back(w);
    end
  endfunction

  // mode 0: Ready high at each Valid; 1: Ready low for 5 cycles per word; 2: random Ready.
  task automatic run_dump(input string name, input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                          input logic sk, input int mode, input int exp_cycles,
                          input bit poke, input bit restart);
    int            cycles;
    int            stall;
    bit            held;
    bit            seen_done;
    logic [DW-1:0] hd;
    logic [AW-1:0] ha;
    word_t         w;
    cycles    = 0;
    stall     = 0;
    held      = 1'b0;
    seen_done = 1'b0;
    hd        = '0;
    ha        = '0;
    build_expected(sa, ea, sk);
    StartAddr = sa;
    EndAddr   = ea;
    SkipZero  = sk;
    Start     = 1'b1;
    Ready     = 1'b0;
    tick();
    cycles = 1;
    Start  = 1'b0;
    check({name, " busy after start"}, 64'(Busy), 64'd1);
    while (cycles < 3000) begin
      if (Done) begin
        seen_done = 1'b1;
        break;
      end
      Start = 1'b0;
      if (restart && cycles == 3) begin
        Start     = 1'b1;
        StartAddr = AW'(20);
        EndAddr   = AW'(25);
      end
      if (Valid) begin
        if (!held) begin
          held  = 1'b1;
          hd    = Dout;
          ha    = DoutAddr;
          stall = 0;
          if (poke) regs[ha] = regs[ha] ^ 32'hA5A5_0F0F;
        end else begin
          check({name, " hold data"}, 64'(Dout), 64'(hd));
          check({name, " hold addr"}, 64'(DoutAddr), 64'(ha));
        end
        case (mode)
          0:       Ready = 1'b1;
          1:       Ready = (stall >= 5);
          default: Ready = 1'($urandom_range(0, 1));
        endcase
        stall++;
        if (Ready) begin
          check({name, " word expected"}, 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check({name, " addr"}, 64'(DoutAddr), 64'(w.addr));
            check({name, " data"}, 64'(Dout), 64'(w.data));
          end
          held = 1'b0;
        end
      end else begin
        Ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      tick();
      cycles++;
    end
    Start = 1'b0;
    check({name, " done seen"}, 64'(seen_done), 64'd1);
    check({name, " valid with done"}, 64'(Valid), 64'd0);
    if (exp_cycles > 0) check({name, " start-to-done cycles"}, 64'(cycles), 64'(exp_cycles));
    check({name, " words left"}, 64'(exp_q.size()), 64'd0);
    // Start during DONE must be ignored.
    StartAddr = sa + AW'(7);
    Start     = 1'b1;
    tick();
    Start = 1'b0;
    Ready = 1'b0;
    check({name, " done one cycle"}, 64'(Done), 64'd0);
    check({name, " idle after done"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    int waited;
    for (int i = 0; i < N; i++) regs[i] = '0;

    #2 Rst_n = 1'b0;
    #10;
    check("reset busy", 64'(Busy), 64'd0);
    check("reset valid", 64'(Valid), 64'd0);
    check("reset done", 64'(Done), 64'd0);
    check("reset raddr", 64'(RAddr), 64'd0);
    check("reset dout", 64'(Dout), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();

    for (int i = 0; i < N; i++) regs[i] = DW'(i * 3);
    run_dump("full", AW'(0), AW'(31), 1'b0, 0, 65, 1'b0, 1'b0);
    run_dump("backpressure", AW'(8), AW'(10), 1'b0, 1, 22, 1'b0, 1'b0);
    run_dump("wrap", AW'(30), AW'(1), 1'b0, 0, 9, 1'b0, 1'b0);
    run_dump("single", AW'(7), AW'(7), 1'b0, 0, 3, 1'b0, 1'b0);

    regs[1] = 32'd5; regs[2] = '0; regs[3] = '0; regs[4] = 32'd9; regs[5] = '0;
    run_dump("skipzero", AW'(0), AW'(5), 1'b1, 0, 9, 1'b0, 1'b0);

    run_dump("start ignored", AW'(13), AW'(18), 1'b0, 0, 13, 1'b0, 1'b1);

    regs[12] = 32'h1234_5678;
    run_dump("coherency", AW'(12), AW'(12), 1'b0, 1, 8, 1'b1, 1'b0);

    // Abort while SEND is stalled.
    for (int i = 0; i < N; i++) regs[i] = DW'(i * 3);
    StartAddr = AW'(0);
    EndAddr   = AW'(31);
    SkipZero  = 1'b0;
    Ready     = 1'b0;
    Start     = 1'b1;
    tick();
    Start  = 1'b0;
    waited = 0;
    while (!Valid && waited < 10) begin
      tick();
      waited++;
    end
    check("abort valid reached", 64'(Valid), 64'd1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check("abort valid", 64'(Valid), 64'd0);
    check("abort busy", 64'(Busy), 64'd0);
    check("abort done", 64'(Done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort no late done", 64'(Done | Busy), 64'd0);
    end

    run_dump("after abort", AW'(0), AW'(31), 1'b0, 0, 65, 1'b0, 1'b0);

    // Asynchronous reset while in READ.
    StartAddr = AW'(5);
    EndAddr   = AW'(9);
    Start     = 1'b1;
    tick();
    Start = 1'b0;
    check("pre-reset raddr", 64'(RAddr), 64'd5);
    #2 Rst_n = 1'b0;
    #1;
    check("async reset raddr", 64'(RAddr), 64'd0);
    check("async reset busy", 64'(Busy), 64'd0);
    check("async reset dout", 64'(Dout), 64'd0);
    check("async reset doutaddr", 64'(DoutAddr), 64'd0);
    check("async reset valid/done", 64'(Valid | Done), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) regs[i] = ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom);
      run_dump("random", AW'($urandom_range(0, N - 1)), AW'($urandom_range(0, N - 1)),
               1'($urandom_range(0, 1)), 2, 0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
